// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board renderer.
package chess_pkg;

  typedef logic [3:0] piece_t;
  localparam piece_t PIECE_EMPTY = 4'd15;

  typedef enum logic [2:0] {
    PAL_LIGHT = 3'd0,
    PAL_DARK  = 3'd1,
    PAL_BG    = 3'd2,
    PAL_WHITE = 3'd3,
    PAL_INK   = 3'd4,
    PAL_CUR   = 3'd5,
    PAL_SEL   = 3'd6
  } pal_t;

  // 24-bit RGB per palette index; slot 7 is unused.
  localparam logic [23:0] PALETTE [8] = '{
    24'hEEEED2, 24'h69923E, 24'h4B4847, 24'hFFFFFF,
    24'h000000, 24'hF6F669, 24'hBACA2B, 24'h000000
  };

  // Standard start position, indexed [row][col].
  localparam piece_t START_LAYOUT [8][8] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd2,  4'd1,  4'd0 },
    '{4'd5,  4'd5,  4'd5,  4'd5,  4'd5,  4'd5,  4'd5,  4'd5 },
    '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15},
    '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15},
    '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15},
    '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15},
    '{4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11, 4'd11},
    '{4'd6,  4'd7,  4'd8,  4'd9,  4'd10, 4'd8,  4'd7,  4'd6 }
  };

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/board_state_ram.sv
// 64x4 board-state RAM: one synchronous write port, one read-first read port.
module board_state_ram
  import chess_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [5:0] waddr_i,
  input  piece_t     wdata_i,
  input  logic [5:0] raddr_i,
  output piece_t     rdata_o
);

  piece_t mem_q [64];
  piece_t rdata_q;

  // Read samples the old contents when read and write hit the same square.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/chess_board_renderer.sv
// Procedural checkerboard + board-state RAM + sprite overlay, 3-cycle pipeline.
module chess_board_renderer
  import chess_pkg::*;
#(
  parameter int TILE_SIZE      = 56,
  parameter int BOARD_ORIGIN_X = 16,
  parameter int BOARD_ORIGIN_Y = 16,
  parameter int NUM_SPRITES    = 12,
  parameter int SPRITE_AW      = 16,
  parameter int COLOR_DEPTH    = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic                   pix_valid,
  input  logic                   flip,
  input  logic [2:0]             cursor_row,
  input  logic [2:0]             cursor_col,
  input  logic                   sel_valid,
  input  logic [2:0]             sel_row,
  input  logic [2:0]             sel_col,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [2:0]             wr_row,
  input  logic [2:0]             wr_col,
  input  logic [3:0]             wr_piece,
  output logic [SPRITE_AW-1:0]   sprite_addr,
  input  logic [1:0]             sprite_data,
  output logic [COLOR_DEPTH-1:0] vga_r,
  output logic [COLOR_DEPTH-1:0] vga_g,
  output logic [COLOR_DEPTH-1:0] vga_b,
  output logic                   out_valid,
  output logic                   init_done
);

  localparam int STAGES   = 3;
  localparam int RW       = $clog2(TILE_SIZE);
  localparam int BOARD_PX = 8 * TILE_SIZE;

  // ---------------- board-state FSM ----------------
  state_t     state_q, state_d;
  logic [5:0] sq_q, sq_d;
  logic       ram_we;
  logic [5:0] ram_waddr;
  piece_t     ram_wdata;
  logic [5:0] ram_raddr;
  piece_t     ram_rdata;

  // State and init-square registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= INIT;
      sq_q    <= '0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
    end
  end

  // INIT streams the start layout into the RAM; IDLE accepts external writes.
  always_comb begin
    state_d   = state_q;
    sq_d      = sq_q;
    ram_we    = 1'b0;
    ram_waddr = sq_q;
    ram_wdata = START_LAYOUT[sq_q[5:3]][sq_q[2:0]];
    wr_ready  = 1'b0;
    init_done = 1'b0;
    case (state_q)
      INIT: begin
        ram_we = 1'b1;
        sq_d   = sq_q + 6'd1;
        if (sq_q == 6'd63) state_d = IDLE;
      end
      IDLE: begin
        wr_ready  = 1'b1;
        init_done = 1'b1;
        if (wr_valid) begin
          ram_we    = 1'b1;
          ram_waddr = {wr_row, wr_col};
          ram_wdata = wr_piece;
        end
      end
      default: state_d = INIT;
    endcase
    if (reset) ram_we = 1'b0;
  end

  board_state_ram u_ram (
    .clk_i   (vga_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // ---------------- flip latch ----------------
  logic flip_q;

  // Orientation changes only at the frame origin so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (reset) flip_q <= 1'b0;
    else if (hcount == 10'd0 && vcount == 10'd0) flip_q <= flip;
  end

  // ---------------- S0: tile coordinates ----------------
  logic [9:0]    offx, offy;
  logic          in_b_d;
  logic [2:0]    trow_d, tcol_d;
  logic [RW-1:0] relx_d, rely_d;

  // Pixel -> logical square and in-tile offset; flip rotates both.
  always_comb begin
    offx   = hcount - 10'(BOARD_ORIGIN_X);
    offy   = vcount - 10'(BOARD_ORIGIN_Y);
    in_b_d = (hcount >= 10'(BOARD_ORIGIN_X)) && (hcount < 10'(BOARD_ORIGIN_X + BOARD_PX)) &&
             (vcount >= 10'(BOARD_ORIGIN_Y)) && (vcount < 10'(BOARD_ORIGIN_Y + BOARD_PX));
    tcol_d = 3'(offx / 10'(TILE_SIZE));
    trow_d = 3'(offy / 10'(TILE_SIZE));
    relx_d = RW'(offx % 10'(TILE_SIZE));
    rely_d = RW'(offy % 10'(TILE_SIZE));
    if (flip_q) begin
      tcol_d = 3'd7 - tcol_d;
      trow_d = 3'd7 - trow_d;
      relx_d = RW'(TILE_SIZE - 1) - relx_d;
      rely_d = RW'(TILE_SIZE - 1) - rely_d;
    end
  end

  // RAM read is launched from S0 so the code lands alongside the S0 registers.
  assign ram_raddr = {trow_d, tcol_d};

  logic [STAGES-1:0] vld_pipe_q;
  logic              in_b_s0;
  logic [2:0]        trow_s0, tcol_s0;
  logic [RW-1:0]     relx_s0, rely_s0;

  // S0 registers.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vld_pipe_q[0] <= 1'b0;
      in_b_s0       <= 1'b0;
      trow_s0       <= '0;
      tcol_s0       <= '0;
      relx_s0       <= '0;
      rely_s0       <= '0;
    end else begin
      vld_pipe_q[0] <= pix_valid;
      in_b_s0       <= in_b_d;
      trow_s0       <= trow_d;
      tcol_s0       <= tcol_d;
      relx_s0       <= relx_d;
      rely_s0       <= rely_d;
    end
  end

  // ---------------- S1: sprite address + background ----------------
  logic                 spr_hit_d;
  logic [SPRITE_AW-1:0] addr_d;
  pal_t                 bg_d;

  // Sprite address for drawable codes and background by precedence.
  always_comb begin
    spr_hit_d = in_b_s0 && (int'(ram_rdata) < NUM_SPRITES);
    addr_d    = '0;
    if (spr_hit_d)
      addr_d = SPRITE_AW'(ram_rdata) * SPRITE_AW'(TILE_SIZE * TILE_SIZE) +
               SPRITE_AW'(rely_s0) * SPRITE_AW'(TILE_SIZE) + SPRITE_AW'(relx_s0);
    if (!in_b_s0)
      bg_d = PAL_BG;
    else if (sel_valid && trow_s0 == sel_row && tcol_s0 == sel_col)
      bg_d = PAL_SEL;
    else if (trow_s0 == cursor_row && tcol_s0 == cursor_col)
      bg_d = PAL_CUR;
    else if (trow_s0[0] ^ tcol_s0[0])
      bg_d = PAL_DARK;
    else
      bg_d = PAL_LIGHT;
  end

  logic                 spr_hit_s1;
  pal_t                 bg_s1;
  logic [SPRITE_AW-1:0] sprite_addr_q;

  // S1 registers; sprite_data answers this address on the next edge.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vld_pipe_q[1] <= 1'b0;
      spr_hit_s1    <= 1'b0;
      bg_s1         <= PAL_BG;
      sprite_addr_q <= '0;
    end else begin
      vld_pipe_q[1] <= vld_pipe_q[0];
      spr_hit_s1    <= spr_hit_d;
      bg_s1         <= bg_d;
      sprite_addr_q <= addr_d;
    end
  end

  assign sprite_addr = sprite_addr_q;

  // ---------------- S2: composition ----------------
  pal_t        pal_d;
  logic [23:0] rgb24;

  // Sprite pixel overrides background unless transparent (0).
  always_comb begin
    pal_d = bg_s1;
    if (spr_hit_s1) begin
      case (sprite_data)
        2'd1:    pal_d = PAL_INK;
        2'd2:    pal_d = PAL_BG;
        2'd3:    pal_d = PAL_WHITE;
        default: pal_d = bg_s1;
      endcase
    end
    rgb24 = PALETTE[pal_d];
  end

  logic [COLOR_DEPTH-1:0] r_q, g_q, b_q;

  // Output registers; blank outside the visible area. Channels keep the MSBs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vld_pipe_q[2] <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      vld_pipe_q[2] <= vld_pipe_q[1];
      r_q <= vld_pipe_q[1] ? COLOR_DEPTH'({rgb24[23:16], {COLOR_DEPTH{1'b0}}} >> 8) : '0;
      g_q <= vld_pipe_q[1] ? COLOR_DEPTH'({rgb24[15:8],  {COLOR_DEPTH{1'b0}}} >> 8) : '0;
      b_q <= vld_pipe_q[1] ? COLOR_DEPTH'({rgb24[7:0],   {COLOR_DEPTH{1'b0}}} >> 8) : '0;
    end
  end

  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;
  assign out_valid = vld_pipe_q[STAGES-1];

endmodule

// File: tb/tb_chess_board_renderer.sv
// Directed bench for chess_board_renderer.
module tb_chess_board_renderer;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic        pix_valid, flip;
  logic [2:0]  cursor_row, cursor_col, sel_row, sel_col, wr_row, wr_col;
  logic        sel_valid, wr_valid, wr_ready;
  logic [3:0]  wr_piece;
  logic [15:0] sprite_addr;
  logic [1:0]  sprite_data;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        out_valid, init_done;

  logic [15:0] rom_addr;
  logic [1:0]  rom_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 vga_clk = ~vga_clk;

  // Sprite ROM model: one non-zero location, everything else transparent.
  always_comb sprite_data = (sprite_addr == rom_addr) ? rom_val : 2'd0;

  chess_board_renderer dut (
    .vga_clk(vga_clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .pix_valid(pix_valid), .flip(flip),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .sel_valid(sel_valid), .sel_row(sel_row), .sel_col(sel_col),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
    .wr_piece(wr_piece), .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .out_valid(out_valid), .init_done(init_done)
  );

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic park();
    hcount    = 10'd639;
    vcount    = 10'd479;
    pix_valid = 1'b0;
  endtask

  // One visible pixel through the pipe; optional same-cycle board write.
  task automatic render(input string tag, input logic [9:0] h, input logic [9:0] v,
                        input logic wr, input logic [31:0] ea, input logic [23:0] ergb);
    hcount = h; vcount = v; pix_valid = 1'b1; wr_valid = wr;
    tick();
    park(); wr_valid = 1'b0;
    tick();
    chk({tag, ".addr"}, {16'd0, sprite_addr}, ea);
    chk({tag, ".vld2"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, ".vld3"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".rgb"},  {8'd0, vga_r, vga_g, vga_b}, {8'd0, ergb});
    tick();
    chk({tag, ".blank"}, {8'd0, vga_r, vga_g, vga_b}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; park(); flip = 1'b0;
    cursor_row = 3'd5; cursor_col = 3'd6;
    sel_valid = 1'b0; sel_row = 3'd0; sel_col = 3'd0;
    wr_valid = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_piece = 4'd0;
    rom_addr = 16'hFFFF; rom_val = 2'd0;

    // 1. reset state and INIT length
    tick(); tick();
    chk("rst.rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst.vld", {31'd0, out_valid}, 32'd0);
    chk("rst.wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst.init_done", {31'd0, init_done}, 32'd0);
    chk("rst.addr", {16'd0, sprite_addr}, 32'd0);
    reset = 1'b0;
    repeat (63) tick();
    chk("init63.done", {31'd0, init_done}, 32'd0);
    tick();
    chk("init64.done", {31'd0, init_done}, 32'd1);
    chk("init64.ready", {31'd0, wr_ready}, 32'd1);
    render("sq04", 10'd240, 10'd16, 1'b0, 32'd12544, 24'hEEEED2);
    render("sq33", 10'd184, 10'd184, 1'b0, 32'd0, 24'hEEEED2);

    // 2. first square, out-of-board pixel
    render("sq00", 10'd16, 10'd16, 1'b0, 32'd0, 24'hEEEED2);
    render("oob", 10'd5, 10'd5, 1'b0, 32'd0, 24'h4B4847);

    // 3. sprite overlay on square (0,1)
    rom_addr = 16'd3136; rom_val = 2'd3;
    render("sq01.white", 10'd72, 10'd16, 1'b0, 32'd3136, 24'hFFFFFF);
    rom_val = 2'd0;
    render("sq01.clear", 10'd72, 10'd16, 1'b0, 32'd3136, 24'h69923E);
    rom_val = 2'd1;
    render("sq01.ink", 10'd72, 10'd16, 1'b0, 32'd3136, 24'h000000);

    // 4. flip only latches at the frame origin
    flip = 1'b1; tick(); flip = 1'b0; tick();
    rom_addr = 16'd113; rom_val = 2'd1;
    render("noflip", 10'd17, 10'd18, 1'b0, 32'd113, 24'h000000);
    flip = 1'b1; hcount = 10'd0; vcount = 10'd0; tick(); park();
    rom_addr = 16'd21951; rom_val = 2'd2;
    render("flip.px16", 10'd16, 10'd16, 1'b0, 32'd21951, 24'h4B4847);
    render("flip.px17", 10'd17, 10'd18, 1'b0, 32'd21838, 24'hEEEED2);
    flip = 1'b0; hcount = 10'd0; vcount = 10'd0; tick(); park();

    // 5. write/read collision, then cursor and selection
    rom_addr = 16'd0; rom_val = 2'd3;
    wr_row = 3'd4; wr_col = 3'd4; wr_piece = 4'd9;
    render("wr44.old", 10'd240, 10'd240, 1'b1, 32'd0, 24'hEEEED2);
    rom_addr = 16'd28224; rom_val = 2'd0;
    render("wr44.new", 10'd240, 10'd240, 1'b0, 32'd28224, 24'hEEEED2);
    cursor_row = 3'd4; cursor_col = 3'd4;
    sel_valid = 1'b1; sel_row = 3'd4; sel_col = 3'd4;
    render("sel44", 10'd240, 10'd240, 1'b0, 32'd28224, 24'hBACA2B);
    sel_valid = 1'b0;
    render("cur44", 10'd240, 10'd240, 1'b0, 32'd28224, 24'hF6F669);
    cursor_row = 3'd5; cursor_col = 3'd6;

    // 6. reset during an IDLE write, then again mid-INIT
    wr_valid = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_piece = 4'd12; reset = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("rst2.done", {31'd0, init_done}, 32'd0);
    chk("rst2.ready", {31'd0, wr_ready}, 32'd0);
    reset = 1'b0;
    repeat (30) tick();
    chk("init30.ready", {31'd0, wr_ready}, 32'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (63) tick();
    chk("reinit63.done", {31'd0, init_done}, 32'd0);
    tick();
    chk("reinit64.done", {31'd0, init_done}, 32'd1);
    rom_addr = 16'hFFFF; rom_val = 2'd0;
    render("re.sq00", 10'd17, 10'd18, 1'b0, 32'd113, 24'hEEEED2);
    render("re.sq44", 10'd240, 10'd240, 1'b0, 32'd0, 24'hEEEED2);
    render("re.sq77", 10'd408, 10'd408, 1'b0, 32'd18816, 24'hEEEED2);
    render("re.sq13", 10'd184, 10'd72, 1'b0, 32'd15680, 24'hEEEED2);
    render("re.sq62", 10'd128, 10'd352, 1'b0, 32'd34496, 24'hEEEED2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chess_board_renderer.md
Name: chess_board_renderer

Overview:
Pipelined, parametrised board/piece renderer for the 640x480 VGA path. It replaces the fixed ROM-bitmap board and the hard-coded initial piece map with three things: a procedurally generated checkerboard, a writable 64-entry board-state RAM, and cursor/selection overlays. It sits between the VGA timing generator (hcount/vcount) and the RGB output mux, and fetches piece pixels from an external sprite ROM with 1-cycle read latency.

Parameters:
TILE_SIZE, 56, tile and sprite edge in pixels
BOARD_ORIGIN_X, 16, left pixel column of the board
BOARD_ORIGIN_Y, 16, top pixel row of the board
NUM_SPRITES, 12, piece sprites stored in the ROM, codes 0..NUM_SPRITES-1
SPRITE_AW, 16, sprite ROM address width; must be at least clog2(NUM_SPRITES*TILE_SIZE^2)
COLOR_DEPTH, 8, bits per colour channel

Ports:
vga_clk  in  1  pixel clock
reset  in  1  synchronous, active-high
hcount  in  10  current pixel column
vcount  in  10  current pixel row
pix_valid  in  1  hcount/vcount lie in the visible area
flip  in  1  1 = render from black's side (board rotated 180 degrees)
cursor_row, cursor_col  in  3 each  cursor square
sel_valid  in  1  a square is selected
sel_row, sel_col  in  3 each  selected square
wr_valid  in  1  board write request
wr_ready  out  1  write accepted when wr_valid and wr_ready are both high
wr_row, wr_col  in  3 each  square to write
wr_piece  in  4  piece code; 15 = empty
sprite_addr  out  SPRITE_AW  sprite ROM address
sprite_data  in  2  sprite ROM data; valid 1 cycle after sprite_addr
vga_r, vga_g, vga_b  out  COLOR_DEPTH each  pixel colour
out_valid  out  1  pix_valid delayed to align with RGB
init_done  out  1  high once the board RAM holds the start position

Behaviour:
- Reset (synchronous, active-high) forces: RGB=0, out_valid=0, wr_ready=0, init_done=0, sprite_addr=0, flip_q=0, and the FSM to INIT with sq=0.
- FSM states:
  - INIT: writes the standard layout to RAM[sq], then sq++. Row 0 gets {0,1,2,3,4,2,1,0}; row 1 gets 5; rows 2..5 get 15; row 6 gets 11; row 7 gets {6,7,8,9,10,8,7,6}.
  - INIT exit: after sq=63 is written, goes to IDLE. INIT lasts exactly 64 cycles.
  - IDLE: init_done=1 and wr_ready=1. A handshake writes RAM[wr_row*8+wr_col] on that edge. Writes take effect only after INIT, so wr_ready stays 0 during INIT.
- Reset asserted mid-INIT or mid-IDLE restarts INIT from sq=0; any RAM write in that cycle is dropped.
- flip_q samples flip only when hcount==0 and vcount==0, so there is no mid-frame tearing.
- Pipeline: fixed 3-cycle latency from hcount/vcount/pix_valid to RGB/out_valid.
  - S0 (registered): in_board = pixel inside the 8*TILE_SIZE square at the origin. Computes trow and tcol (integer divide of the offset by TILE_SIZE), rel_x and rel_y. If flip_q: trow=7-trow, tcol=7-tcol, rel_x=TILE_SIZE-1-rel_x, rel_y=TILE_SIZE-1-rel_y (sprites rotate too).
  - S1 (registered): RAM read-first lookup of code=RAM[trow*8+tcol]. sprite_addr = code*TILE_SIZE^2 + rel_y*TILE_SIZE + rel_x when code<NUM_SPRITES, else 0.
  - S2: sprite_data arrives; composition is registered to the outputs.
- A write to the square being read in the same cycle returns the old value; the new value is visible from the next read.
- Background colour precedence (highest first):
  - out of board: BG
  - sel_valid and square == sel: SEL
  - square == cursor: CUR
  - else LIGHT if (trow+tcol) is even, otherwise DARK
  - The cursor/selection comparison uses logical (post-flip) coordinates.
- Sprite overlay applies when code<NUM_SPRITES and sprite_data!=0: 1 gives INK, 2 gives BG, 3 gives WHITE. Codes 12..15 draw no sprite.
- When out_valid=0, RGB=0 (blanking).
- Palette (24-bit RGB): LIGHT EEEED2, DARK 69923E, BG 4B4847, WHITE FFFFFF, INK 000000, CUR F6F669, SEL BACA2B.
- All address arithmetic is done at SPRITE_AW bits, with no truncation inside the board.

Decomposition:
- Package chess_pkg holds:
  - piece_t (4-bit codes, PIECE_EMPTY=15)
  - palette-index enum and the 24-bit palette constant array
  - the START_LAYOUT[8][8] constant
  - FSM state enum {INIT, IDLE}
- One sub-module, board_state_ram: 64x4, one synchronous write port, one read-first synchronous read port, inferable as MLAB/registers.

Test Plan:
1. Reset, release, wait 64 cycles: init_done rises on cycle 64 and wr_ready=1; reading square (0,4) gives code 4, square (3,3) gives 15.
2. hcount=16, vcount=16, flip=0, sprite ROM returns 0: out_valid and RGB after exactly 3 cycles; sprite_addr=0 at cycle 2; RGB=EEEED2 (square 0,0 is light).
3. hcount=72, vcount=16, ROM returns 3 at the addressed location: square (0,1), code 1, sprite_addr=3136; RGB=FFFFFF. Same pixel with sprite_data=0 gives 69923E.
4. flip pulsed mid-frame, then held from vcount=0,hcount=0: unchanged until the frame start. Afterwards pixel (16,16) maps to square (7,7) with rel=(55,55): sprite_addr=6*3136+55*56+55=21951.
5. Write (4,4)=9 in the same cycle the pipeline reads (4,4): that read shows 15, the next frame shows code 9. cursor=(4,4) with sel_valid=1, sel=(4,4): background BACA2B. With sel_valid=0: F6F669.
6. Assert reset at INIT sq=30 and again during an IDLE write: the write is dropped, init_done=0, INIT reruns for a full 64 cycles, and the RAM matches START_LAYOUT.
